// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   MDU_WIDTH   - default operand and HI/LO width
//   OP_*        - operation encodings carried on the 2-bit op bus
//   mdu_state_e - control FSM states (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if
// Request/result bundle between the core and the multiply/divide unit.
//   start, op, a, b      - operation request (op: 00 MULTU, 01 MULT,
//                          10 DIVU, 11 DIV)
//   wr_hi, wr_lo, wdata  - MTHI / MTLO writes
//   busy, done           - operation in progress / result just written
//   hi, lo               - architectural HI and LO registers
// master: the core side; slave: the unit itself.
// ---------------------------------------------------------------------------
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_shift_datapath.sv
// ---------------------------------------------------------------------------
// mdu_shift_datapath
// Radix-2 iteration engine shared by multiply and divide. Works purely on
// unsigned magnitudes; sign handling lives in the parent.
//   clk, reset   - clock, synchronous active-high reset
//   load         - capture init (low half of the iteration register) and
//                  operand, clear the iteration counter
//   step         - perform one iteration
//   is_div       - divide mode (present only when MDU_DIV_EN is defined)
//   init         - multiplier (multiply) or dividend (divide) magnitude
//   operand      - multiplicand (multiply) or divisor (divide) magnitude
//   last         - the current step is the final (WIDTH-th) iteration
//   result_next  - iteration register value after the current step:
//                  {hi,lo} product, or {remainder, quotient}
// Macro: MDU_DIV_EN compiles in the shift-subtract (restoring divide) path.
// ---------------------------------------------------------------------------
module mdu_shift_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
`ifdef MDU_DIV_EN
    input  logic               is_div,
`endif
    input  logic [WIDTH-1:0]   init,
    input  logic [WIDTH-1:0]   operand,
    output logic               last,
    output logic [2*WIDTH-1:0] result_next
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] iter_q;
    logic [2*WIDTH-1:0] iter_next;
    logic [WIDTH-1:0]   operand_q;
    logic [CNT_W-1:0]   cnt_q;

`ifdef MDU_DIV_EN
    logic [WIDTH:0]     acc_in;
    logic [WIDTH:0]     addend;
    logic               carry_in;
    logic [WIDTH+1:0]   sum;

    // One adder serves both modes. Multiply adds the multiplicand into the
    // upper half and shifts right; divide subtracts the divisor from the
    // left-shifted partial remainder, and the carry out is the quotient bit
    // (carry set means no borrow, i.e. the subtraction fits).
    always_comb begin
        if (is_div) begin
            acc_in   = iter_q[2*WIDTH-1:WIDTH-1];
            addend   = ~{1'b0, operand_q};
            carry_in = 1'b1;
        end else begin
            acc_in   = {1'b0, iter_q[2*WIDTH-1:WIDTH]};
            addend   = iter_q[0] ? {1'b0, operand_q} : '0;
            carry_in = 1'b0;
        end
        sum = {1'b0, acc_in} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, carry_in};
        if (is_div) begin
            iter_next = sum[WIDTH+1] ? {sum[WIDTH-1:0], iter_q[WIDTH-2:0], 1'b1}
                                     : {iter_q[2*WIDTH-2:0], 1'b0};
        end else begin
            iter_next = {sum[WIDTH:0], iter_q[WIDTH-1:1]};
        end
    end
`else
    logic [WIDTH:0]     sum;

    // Shift-add multiply: the carry of the add becomes the new MSB as the
    // whole register shifts right, consuming one multiplier bit per step.
    always_comb begin
        sum       = {1'b0, iter_q[2*WIDTH-1:WIDTH]}
                  + (iter_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
        iter_next = {sum, iter_q[WIDTH-1:1]};
    end
`endif

    // Iteration register, operand register and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q    <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
        end else if (load) begin
            iter_q    <= {{WIDTH{1'b0}}, init};
            operand_q <= operand;
            cnt_q     <= '0;
        end else if (step) begin
            iter_q    <= iter_next;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    assign last        = (cnt_q == CNT_W'(WIDTH - 1));
    assign result_next = iter_next;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   bus    - mdu_if.slave: start/op/a/b request, wr_hi/wr_lo/wdata MTHI/MTLO,
//            busy/done status, hi/lo architectural registers
// A started operation occupies RUN for WIDTH cycles, writes hi/lo on the
// edge into DONE, and DONE lasts one cycle.
// Macro: MDU_DIV_EN enables DIV/DIVU. Without it a divide request goes
// straight from IDLE to DONE and leaves hi/lo untouched.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    mdu_state_e         state_q;
    mdu_state_e         state_d;

    logic               start_op;
    logic               load;
    logic               dp_last;
    logic [2*WIDTH-1:0] dp_result;
    logic [WIDTH-1:0]   dp_init;
    logic [WIDTH-1:0]   dp_operand;

    logic               neg_a_d;
    logic               neg_b_d;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               mt_allowed;

`ifdef MDU_DIV_EN
    logic               is_div_q;
    logic               b_zero_q;
`endif

    assign start_op = (state_q == ST_IDLE) && bus.start;

    // op[0] marks the signed variants (MULT, DIV); the datapath only ever
    // sees magnitudes.
    assign neg_a_d = bus.op[0] & bus.a[WIDTH-1];
    assign neg_b_d = bus.op[0] & bus.b[WIDTH-1];
    assign mag_a   = neg_a_d ? -bus.a : bus.a;
    assign mag_b   = neg_b_d ? -bus.b : bus.b;

`ifdef MDU_DIV_EN
    assign load       = start_op;
    assign dp_init    = bus.op[1] ? mag_a : mag_b;
    assign dp_operand = bus.op[1] ? mag_b : mag_a;
`else
    assign load       = start_op && !bus.op[1];
    assign dp_init    = mag_b;
    assign dp_operand = mag_a;
`endif

    mdu_shift_datapath #(
        .WIDTH       (WIDTH)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .step        (state_q == ST_RUN),
`ifdef MDU_DIV_EN
        .is_div      (is_div_q),
`endif
        .init        (dp_init),
        .operand     (dp_operand),
        .last        (dp_last),
        .result_next (dp_result)
    );

    // Operand sign flags captured with the request, used to fix up the
    // final magnitudes.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
`endif
        end else if (start_op) begin
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
`ifdef MDU_DIV_EN
            is_div_q <= bus.op[1];
            b_zero_q <= (bus.b == '0);
`endif
        end
    end

    // Sign fix-up. Product is negated when operand signs differ. Quotient
    // follows the same rule, remainder follows the dividend. A zero divisor
    // leaves the quotient at all ones; negating the remainder |a| when a
    // was negative restores hi = a.
    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -dp_result : dp_result;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            res_lo = ((neg_a_q ^ neg_b_q) && !b_zero_q) ? -dp_result[WIDTH-1:0]
                                                        : dp_result[WIDTH-1:0];
            res_hi = neg_a_q ? -dp_result[2*WIDTH-1:WIDTH]
                             : dp_result[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef MDU_DIV_EN
                    state_d = ST_RUN;
`else
                    state_d = bus.op[1] ? ST_DONE : ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (dp_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // MTHI/MTLO are accepted in DONE and in IDLE unless a new operation is
    // being started in the same cycle.
    assign mt_allowed = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !bus.start);

    // HI/LO registers: result on the final iteration edge, otherwise writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if ((state_q == ST_RUN) && dp_last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (mt_allowed) begin
            if (bus.wr_hi) begin
                hi_q <= bus.wdata;
            end
            if (bus.wr_lo) begin
                lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The block SHALL have port a  input  WIDTH  rs operand (dividend or multiplicand).
REQ-007 The block SHALL have port b  input  WIDTH  rt operand (divisor or multiplier).
REQ-008 The block SHALL have port wr_hi / wr_lo  input  1 each  MTHI / MTLO write strobes.
REQ-009 The block SHALL have port wdata  input  WIDTH  data for MTHI / MTLO.
REQ-010 The block SHALL have port busy  output  1  high while an operation runs; the core stalls on MFHI/MFLO.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking that the result has been written.
REQ-012 The block SHALL have ports hi and lo  output  WIDTH each  architectural HI and LO registers.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at edge k SHALL latch a, b and op, then enter RUN.
REQ-015 RUN SHALL last exactly WIDTH cycles (edges k+1 through k+WIDTH), one radix-2 iteration per cycle.
REQ-016 RUN SHALL then enter DONE, writing hi and lo at the edge that enters DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 start asserted in DONE SHALL be ignored.
REQ-019 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE; start SHALL be ignored in RUN.
REQ-020 MULTU SHALL set {hi,lo} to the unsigned 2*WIDTH-bit product of a and b.
REQ-021 MULT SHALL set {hi,lo} to the two's-complement product, computed on magnitudes with the sign fixed after the last iteration.
REQ-022 DIVU SHALL set lo to the unsigned quotient and hi to the unsigned remainder.
REQ-023 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero (b=0) SHALL give lo=all ones and hi=a, for both DIV and DIVU.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-026 wr_hi and wr_lo SHALL load wdata in IDLE or DONE and SHALL be ignored in RUN.
REQ-027 In IDLE, start=1 together with wr_hi or wr_lo SHALL start the operation and discard the write.
REQ-028 A write in DONE SHALL take effect at the edge leaving DONE and override the new result.
REQ-029 hi and lo SHALL hold their value in every case not listed above.

Reset
REQ-030 reset=1 at any edge SHALL force IDLE and clear hi, lo, busy, done and the internal iteration registers to 0.
REQ-031 reset SHALL take priority over start, wr_hi and wr_lo.
REQ-032 reset in RUN SHALL abandon the operation and SHALL NOT pulse done.

Configuration
REQ-033 The divide logic SHALL be compiled in only when macro MDU_DIV_EN is defined.
REQ-034 With MDU_DIV_EN defined, DIV and DIVU SHALL behave per REQ-022 to REQ-025.
REQ-035 Without MDU_DIV_EN, start with op[1]=1 SHALL go from IDLE straight to DONE in one cycle with hi and lo unchanged, busy staying 0 and done pulsing.
REQ-036 Without MDU_DIV_EN, MULT, MULTU, MTHI and MTLO SHALL be unaffected.

Structure
REQ-037 Package mdu_pkg SHALL hold the WIDTH default, the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the FSM state enum.
REQ-038 Sub-module mdu_shift_datapath SHALL hold the iteration register, the shift-add/shift-subtract adder and the iteration counter.
REQ-039 mult_div_unit SHALL hold the FSM, the sign handling and the HI/LO registers.

Verification
REQ-040 MULTU: a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high 32 cycles; done one cycle later.
REQ-041 MULT: a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-042 DIV: a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU: a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-043 Start at RUN cycle 10 with a=5, b=5 -> ignored; result is that of the first operation. wr_lo=1 during RUN -> lo unchanged.
REQ-044 Reset asserted at RUN cycle 16 -> next cycle state IDLE, hi=lo=0, busy=0, and done never pulses.
REQ-045 Build without MDU_DIV_EN, DIVU a=9, b=3 -> done the next cycle, busy stays 0, hi and lo keep their prior value.
